// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction fetch front end with a prefetch queue.
//
// Issues in-order word fetches to a variable-latency instruction memory and
// buffers returned words, each paired with its next-PC, in a DEPTH-entry FIFO
// that feeds the ID stage through a valid/ready handshake. A taken branch
// from EX redirects fetch, empties the FIFO and arranges for every response
// still in flight to be discarded.
//
// Ports:
//   CLK          clock, all state on posedge
//   RST_X        asynchronous active-low reset
//   IMEM_REQ     fetch request valid
//   IMEM_ADDR    fetch byte address (bits [1:0] always 0)
//   IMEM_RDY     memory accepts the request this cycle
//   IMEM_RVALID  response valid (in request order, no backpressure)
//   IMEM_RDATA   response instruction word
//   BR_TKN       taken-branch pulse from EX
//   BR_TPC       branch target (bits [1:0] ignored)
//   ID_VALID     ID_IR/ID_NPC hold a valid instruction
//   ID_READY     ID consumes the head entry
//   ID_IR        head instruction word
//   ID_NPC       head instruction address + 4
//
// Configuration macro:
//   IFQ_NOP_FILL_EN  when defined, ID_IR shows NOP_WORD while the queue is
//                    empty; otherwise it shows 0.

module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] NOP_WORD = 32'h0000_0020
) (
   input  logic        CLK,
   input  logic        RST_X,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_RDY,
   input  logic        IMEM_RVALID,
   input  logic [31:0] IMEM_RDATA,
   input  logic        BR_TKN,
   input  logic [31:0] BR_TPC,
   output logic        ID_VALID,
   input  logic        ID_READY,
   output logic [31:0] ID_IR,
   output logic [31:0] ID_NPC
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

`ifdef IFQ_NOP_FILL_EN
   localparam logic [31:0] EMPTY_IR = NOP_WORD;
`else
   localparam logic [31:0] EMPTY_IR = 32'h0000_0000;
   logic [31:0] unused_nop_word;
   assign unused_nop_word = NOP_WORD;
`endif

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;

   logic [31:0]   ir_mem  [DEPTH];
   logic [31:0]   npc_mem [DEPTH];

   logic [CW:0]   credit_used;
   logic [31:0]   br_pc;
   logic          accept;
   logic          push;
   logic          pop;
   logic          unused_tpc_bits;

   assign unused_tpc_bits = ^BR_TPC[1:0];
   assign br_pc           = {BR_TPC[31:2], 2'b00};

   // Buffered plus outstanding words may never exceed DEPTH, so every
   // response always has a free slot waiting for it.
   assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};

   // Gated by RST_X so the request is held low while reset is asserted.
   assign IMEM_REQ  = RST_X & ~BR_TKN & (credit_used < (CW+1)'(DEPTH));
   assign IMEM_ADDR = fetch_pc_q;
   assign accept    = IMEM_REQ & IMEM_RDY;

   // Responses owed to a pre-redirect request (drop > 0) or arriving in the
   // redirect cycle itself never enter the FIFO.
   assign push = IMEM_RVALID & ~BR_TKN & (drop_q == '0);

   assign ID_VALID = (count_q != '0);
   assign pop      = ID_VALID & ID_READY & ~BR_TKN;

   // ID outputs come straight from storage; no bypass from IMEM_RDATA.
   assign ID_IR  = ID_VALID ? ir_mem[rd_ptr_q]  : EMPTY_IR;
   assign ID_NPC = ID_VALID ? npc_mem[rd_ptr_q] : 32'h0000_0000;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      drop_d     = drop_q;
      inflight_d = inflight_q + CW'(accept) - CW'(IMEM_RVALID);

      if (BR_TKN) begin
         fetch_pc_d = br_pc;
         resp_pc_d  = br_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         // inflight already counts the responses still owed to an earlier
         // redirect, so everything outstanding after this edge is stale.
         drop_d     = inflight_q - CW'(IMEM_RVALID);
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (push) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            resp_pc_d = resp_pc_q + 32'd4;
         end
         if (IMEM_RVALID && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         fetch_pc_q <= '0;
         resp_pc_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // Storage is qualified by count, so it needs no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         ir_mem[wr_ptr_q]  <= IMEM_RDATA;
         npc_mem[wr_ptr_q] <= resp_pc_q + 32'd4;
      end
   end

   push_not_full: assert property (@(posedge CLK) disable iff (!RST_X)
      push |-> (count_q != CW'(DEPTH)));

endmodule
